// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer engine: control states,
// rescale table and saturation helpers.
package fc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2,
        S_OUTPUT = 2'd3
    } fc_state_e;

    localparam int RESCALE_SHIFT = 16;
    localparam int FINISH_STAGES = 3;

    // Index by cfg_layer; entry 3 is unity (256 >> 16 == >> 8).
    localparam logic [3:0][8:0] SCALE = {9'd256, 9'd164, 9'd156, 9'd199};

    function automatic logic sat_over(input logic signed [63:0] x, input int w);
        return x > ((64'sd1 <<< (w - 1)) - 64'sd1);
    endfunction

    function automatic logic sat_under(input logic signed [63:0] x, input int w);
        return x < -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fc_lane.sv
// One output neuron: saturating multiply-accumulate followed by a
// 3-stage bias / ReLU / rescale pipeline that advances only while pipe_en.
module fc_lane
    import fc_pkg::*;
#(
    parameter int BITWIDTH     = 8,
    parameter int BITWIDTH_ACC = 24
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clear,
    input  logic                       acc_en,
    input  logic                       pipe_en,
    input  logic [1:0]                 layer,
    input  logic [BITWIDTH-1:0]        in_data,
    input  logic signed [BITWIDTH-1:0] weight,
    input  logic signed [BITWIDTH-1:0] bias_in,
    output logic [BITWIDTH-1:0]        result,
    output logic                       sat_flag
);
    localparam int PROD_W = 2 * BITWIDTH + 1;
    localparam int SUM_W  = BITWIDTH_ACC + 1;
    localparam int SCL_W  = BITWIDTH_ACC + 9;
    localparam logic signed [BITWIDTH_ACC-1:0] ACC_MAX = {1'b0, {(BITWIDTH_ACC-1){1'b1}}};
    localparam logic signed [BITWIDTH_ACC-1:0] ACC_MIN = {1'b1, {(BITWIDTH_ACC-1){1'b0}}};

    logic signed [BITWIDTH_ACC-1:0] acc_reg;
    logic signed [BITWIDTH-1:0]     bias_reg;
    logic signed [BITWIDTH_ACC-1:0] biased_reg;
    logic [BITWIDTH_ACC-1:0]        relu_reg;
    logic [BITWIDTH-1:0]            result_reg;
    logic                           sat_reg;

    logic signed [BITWIDTH:0]       data_s;
    logic signed [PROD_W-1:0]       prod;
    logic signed [SUM_W-1:0]        acc_sum;
    logic signed [SUM_W-1:0]        bias_sum;
    logic signed [BITWIDTH_ACC-1:0] acc_next;
    logic signed [BITWIDTH_ACC-1:0] biased_next;
    logic                           acc_ovf;
    logic [SCL_W-1:0]               scaled;
    logic [SCL_W-1:0]               shifted;
    logic [BITWIDTH-1:0]            rescaled;

    always_comb begin
        // in_data is unsigned: a zero MSB keeps it positive in the signed product.
        data_s  = {1'b0, in_data};
        prod    = PROD_W'(data_s) * PROD_W'(weight);
        acc_sum = SUM_W'(acc_reg) + SUM_W'(prod);
        acc_ovf = sat_over(64'(acc_sum), BITWIDTH_ACC) || sat_under(64'(acc_sum), BITWIDTH_ACC);
        if (sat_over(64'(acc_sum), BITWIDTH_ACC)) begin
            acc_next = ACC_MAX;
        end else if (sat_under(64'(acc_sum), BITWIDTH_ACC)) begin
            acc_next = ACC_MIN;
        end else begin
            acc_next = acc_sum[BITWIDTH_ACC-1:0];
        end

        bias_sum = SUM_W'(acc_reg) + SUM_W'(bias_reg);
        if (sat_over(64'(bias_sum), BITWIDTH_ACC)) begin
            biased_next = ACC_MAX;
        end else if (sat_under(64'(bias_sum), BITWIDTH_ACC)) begin
            biased_next = ACC_MIN;
        end else begin
            biased_next = bias_sum[BITWIDTH_ACC-1:0];
        end

        scaled   = SCL_W'(relu_reg) * SCL_W'(SCALE[layer]);
        shifted  = scaled >> RESCALE_SHIFT;
        rescaled = (|shifted[SCL_W-1:BITWIDTH]) ? {BITWIDTH{1'b1}} : shifted[BITWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg    <= '0;
            bias_reg   <= '0;
            biased_reg <= '0;
            relu_reg   <= '0;
            result_reg <= '0;
            sat_reg    <= 1'b0;
        end else begin
            if (clear) begin
                acc_reg  <= '0;
                sat_reg  <= 1'b0;
                bias_reg <= bias_in;
            end else if (acc_en) begin
                acc_reg <= acc_next;
                if (acc_ovf) begin
                    sat_reg <= 1'b1;
                end
            end
            if (pipe_en) begin
                biased_reg <= biased_next;
                relu_reg   <= biased_reg[BITWIDTH_ACC-1] ? '0 : biased_reg;
                result_reg <= rescaled;
            end
        end
    end

    assign result   = result_reg;
    assign sat_flag = sat_reg;

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: streams an input vector through NUM_PARA
// parallel neuron lanes and emits one rescaled result word per lane.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int BITWIDTH     = 8,
    parameter int BITWIDTH_ACC = 24,
    parameter int NUM_PARA     = 4,
    parameter int MAX_LEN      = 1024
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [$clog2(MAX_LEN+1)-1:0]        cfg_len,
    input  logic [1:0]                          cfg_layer,
    input  logic [NUM_PARA-1:0][BITWIDTH-1:0]   bias,
    output logic                                busy,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BITWIDTH-1:0]                 in_data,
    input  logic [NUM_PARA-1:0][BITWIDTH-1:0]   weight,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_PARA-1:0][BITWIDTH-1:0]   result,
    output logic                                sat_flag
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    fc_state_e          state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   elem_cnt_reg;
    logic [LEN_W-1:0]   len_clamped;
    logic [1:0]         layer_reg;
    logic [1:0]         fin_cnt_reg;
    logic               start_frame;
    logic               accept;
    logic               last_elem;
    logic [NUM_PARA-1:0] lane_sat;

    assign len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    assign start_frame = (state_reg == S_IDLE) && start;
    assign in_ready    = (state_reg == S_ACCUM);
    assign accept      = in_valid && in_ready;
    assign last_elem   = (elem_cnt_reg + LEN_W'(1)) == len_reg;
    assign busy        = (state_reg != S_IDLE);
    assign out_valid   = (state_reg == S_OUTPUT);
    assign sat_flag    = |lane_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            elem_cnt_reg <= '0;
            layer_reg    <= '0;
            fin_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        len_reg      <= len_clamped;
                        layer_reg    <= cfg_layer;
                        elem_cnt_reg <= '0;
                        fin_cnt_reg  <= '0;
                        state_reg    <= (len_clamped == '0) ? S_FINISH : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        elem_cnt_reg <= elem_cnt_reg + LEN_W'(1);
                        if (last_elem) begin
                            state_reg <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // One cycle per pipeline stage; results are valid on the last.
                    fin_cnt_reg <= fin_cnt_reg + 2'd1;
                    if (fin_cnt_reg == 2'(FINISH_STAGES - 1)) begin
                        state_reg <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PARA; gi++) begin : g_lane
            fc_lane #(
                .BITWIDTH     (BITWIDTH),
                .BITWIDTH_ACC (BITWIDTH_ACC)
            ) u_lane (
                .clk      (clk),
                .rstn     (rstn),
                .clear    (start_frame),
                .acc_en   (accept),
                .pipe_en  (state_reg == S_FINISH),
                .layer    (layer_reg),
                .in_data  (in_data),
                .weight   (weight[gi]),
                .bias_in  (bias[gi]),
                .result   (result[gi]),
                .sat_flag (lane_sat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fc_layer_engine.sv
// Randomised bench for fc_layer_engine: stimulus pushes model results into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_fc_layer_engine;
    localparam int BW   = 8;
    localparam int ACCW = 24;
    localparam int NP   = 4;
    localparam int MAXL = 1024;
    localparam int LW   = $clog2(MAXL + 1);

    typedef struct {
        logic [NP-1:0][BW-1:0] res;
        logic                  sat;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  start;
    logic [LW-1:0]         cfg_len;
    logic [1:0]            cfg_layer;
    logic [NP-1:0][BW-1:0] bias;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [BW-1:0]         in_data;
    logic [NP-1:0][BW-1:0] weight;
    logic                  out_valid;
    logic                  out_ready;
    logic [NP-1:0][BW-1:0] result;
    logic                  sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    exp_t exp_q[$];
    logic [NP-1:0][BW-1:0] last_res;
    logic                  last_sat;

    int f_data[MAXL];
    int f_w[MAXL][NP];
    int f_bias[NP];

    always #5 clk = ~clk;

    fc_layer_engine #(
        .BITWIDTH(BW), .BITWIDTH_ACC(ACCW), .NUM_PARA(NP), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
        .cfg_layer(cfg_layer), .bias(bias), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_flag(sat_flag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic straight from the layer definition.
    function automatic exp_t model(input int len, input int layer);
        exp_t   e;
        longint acc;
        longint x;
        longint y;
        longint amax;
        longint amin;
        int     sc[4];
        sc   = '{199, 156, 164, 256};
        amax = 64'sd8388607;
        amin = -64'sd8388608;
        e.sat = 1'b0;
        for (int l = 0; l < NP; l++) begin
            acc = 0;
            for (int k = 0; k < len; k++) begin
                acc = acc + longint'(f_data[k]) * longint'(f_w[k][l]);
                if (acc > amax) begin acc = amax; e.sat = 1'b1; end
                if (acc < amin) begin acc = amin; e.sat = 1'b1; end
            end
            x = acc + longint'(f_bias[l]);
            if (x > amax) x = amax;
            if (x < amin) x = amin;
            if (x < 0) x = 0;
            y = (x * sc[layer]) / 65536;
            if (y > 255) y = 255;
            e.res[l] = BW'(y);
        end
        return e;
    endfunction

    // Monitor: samples 2 time units before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int l = 0; l < NP; l++)
                        check($sformatf("result_lane%0d", l), 64'(result[l]), 64'(e.res[l]));
                    check("sat_flag", 64'(sat_flag), 64'(e.sat));
                    $display("frame %0d out: result=%h sat=%0d", n_out, result, sat_flag);
                end
                last_res = result;
                last_sat = sat_flag;
                n_out++;
            end
        end
    end

    task automatic do_abort();
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("abort_idle", 64'({busy, out_valid}), 64'd0);
    endtask

    // Called at a falling edge with the engine idle; returns at a falling edge, idle.
    task automatic run_frame(input int cfg, input int layer, input int hold,
                             input int abort_at, input int gap_max);
        int len;
        int lat;
        int ir_seen;
        logic [NP-1:0][BW-1:0] held;
        logic held_sat;
        len = (cfg > MAXL) ? MAXL : cfg;
        if (abort_at < 0) exp_q.push_back(model(len, layer));
        cfg_len   = LW'(cfg);
        cfg_layer = 2'(layer);
        for (int l = 0; l < NP; l++) bias[l] = BW'(f_bias[l]);
        out_ready = (hold == 0);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_len   = LW'($urandom);
        cfg_layer = 2'($urandom);
        bias      = NP*BW'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        for (int k = 0; k < len; k++) begin
            if (abort_at == k) begin
                do_abort();
                $display("frame aborted after %0d elements", k);
                return;
            end
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_data  = BW'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = BW'(f_data[k]);
            for (int l = 0; l < NP; l++) weight[l] = BW'(f_w[k][l]);
            if (in_ready !== 1'b1) begin
                check("in_ready_during_accum", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 0;
        ir_seen = (in_ready === 1'b1) ? 1 : 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (in_ready === 1'b1) ir_seen++;
        end
        check("out_latency", 64'(lat), 64'd3);
        check("in_ready_in_finish", 64'(ir_seen), 64'd0);
        if (hold > 0) begin
            held = result;
            held_sat = sat_flag;
            for (int i = 0; i < hold; i++) begin
                if (i == hold / 2) begin
                    start   = 1'b1;
                    cfg_len = LW'(3);
                end
                @(negedge clk);
                start = 1'b0;
                check("hold_result", 64'(result), 64'(held));
                check("hold_sat", 64'(sat_flag), 64'(held_sat));
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_after_handshake", 64'({busy, out_valid}), 64'd0);
    endtask

    task automatic rand_data(input int len);
        for (int k = 0; k < len; k++) begin
            f_data[k] = int'($urandom_range(0, 255));
            for (int l = 0; l < NP; l++) f_w[k][l] = int'($urandom_range(0, 255)) - 128;
        end
        for (int l = 0; l < NP; l++) f_bias[l] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rstn = 1'b0; start = 1'b0; cfg_len = '0; cfg_layer = '0; bias = '0;
        in_valid = 1'b0; in_data = '0; weight = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_sat", 64'(sat_flag), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Two-element frame: lane0 positive, lane1 driven negative.
        rand_data(2);
        f_data[0] = 200; f_data[1] = 200;
        f_w[0][0] = 100; f_w[1][0] = 100;
        f_w[0][1] = -100; f_w[1][1] = -100;
        f_bias[0] = 100; f_bias[1] = 0;
        run_frame(2, 0, 0, -1, 0);
        check("basic_lane0", 64'(last_res[0]), 64'd121);
        check("basic_lane1_relu", 64'(last_res[1]), 64'd0);
        check("basic_sat", 64'(last_sat), 64'd0);
        run_frame(2, 3, 0, -1, 2);
        check("unity_lane0", 64'(last_res[0]), 64'd156);

        // Abort after 5 of 8 elements, then the same frame in full.
        rand_data(8);
        run_frame(8, 1, 0, 5, 1);
        run_frame(8, 1, 0, -1, 1);

        // Positive saturation.
        for (int k = 0; k < 512; k++) begin
            f_data[k] = 255;
            for (int l = 0; l < NP; l++) f_w[k][l] = 127;
        end
        run_frame(512, 0, 0, -1, 0);
        check("possat_flag", 64'(last_sat), 64'd1);
        for (int l = 0; l < NP; l++)
            check($sformatf("possat_lane%0d", l), 64'(last_res[l]), 64'd255);

        // Zero-length frame with output back-pressure.
        for (int l = 0; l < NP; l++) f_bias[l] = 127;
        run_frame(0, 3, 10, -1, 0);
        check("zero_len_result", 64'(last_res), 64'd0);

        // Negative saturation: result clamps at zero through ReLU.
        for (int k = 0; k < 600; k++) begin
            f_data[k] = 255;
            for (int l = 0; l < NP; l++) f_w[k][l] = -128;
        end
        run_frame(600, 1, 0, -1, 0);

        // Over-long length is clamped to MAX_LEN.
        rand_data(MAXL);
        run_frame(2047, 2, 0, -1, 0);

        repeat (12) begin
            len = int'($urandom_range(1, 24));
            rand_data(len);
            run_frame(len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 2);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 SHALL have parameters: BITWIDTH, default 8, data/weight/bias/result width; BITWIDTH_ACC, default 24, accumulator width; NUM_PARA, default 4, output neurons computed in parallel (lanes); MAX_LEN, default 1024, maximum input-vector length.
REQ-002 SHALL have ports as follows. clk  in  1  clock. rstn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports start  in  1  begin frame (sampled in IDLE only); cfg_len  in  $clog2(MAX_LEN+1)  input-vector length; cfg_layer  in  2  rescale selector; bias  in  BITWIDTH x NUM_PARA signed, per-lane bias; busy  out  1  frame in progress.
REQ-004 SHALL have ports in_valid  in  1; in_ready  out  1; in_data  in  BITWIDTH unsigned, one element broadcast to all lanes; weight  in  BITWIDTH x NUM_PARA signed, per-lane weight for that element.
REQ-005 SHALL have ports out_valid  out  1; out_ready  in  1; result  out  BITWIDTH x NUM_PARA unsigned; sat_flag  out  1, some lane accumulator saturated this frame.

Function
REQ-006 SHALL implement FSM IDLE -> ACCUM -> FINISH -> OUTPUT -> IDLE.
REQ-007 IDLE: start=1 SHALL latch cfg_len, cfg_layer and bias, clear accumulators and sat_flag, and go to ACCUM (or to FINISH if cfg_len=0); start outside IDLE SHALL be ignored.
REQ-008 in_ready SHALL be 1 only in ACCUM; an element is accepted when in_valid&&in_ready; in_valid outside ACCUM SHALL be ignored.
REQ-009 Per accepted element, each lane SHALL add signed({1'b0,in_data})*weight, sign-extended to BITWIDTH_ACC, to its accumulator in the same cycle.
REQ-010 Accumulation SHALL saturate to [-2^(BITWIDTH_ACC-1), 2^(BITWIDTH_ACC-1)-1]; any saturation SHALL set sat_flag, sticky until the next start.
REQ-011 After cfg_len elements are accepted, FSM SHALL enter FINISH, a 3-stage registered pipeline: bias add (sign-extended, saturating), ReLU (negative -> 0), rescale.
REQ-012 Rescale SHALL compute floor(x*SCALE[cfg_layer] >> 16), clamped to 2^BITWIDTH-1; SCALE = {199,156,164,256} for cfg_layer 0..3 (3 = unity >>8).
REQ-013 out_valid SHALL rise exactly 3 cycles after entering FINISH; FSM is then in OUTPUT.
REQ-014 In OUTPUT, result and sat_flag SHALL hold stable while out_valid&&!out_ready; on out_valid&&out_ready FSM SHALL return to IDLE next cycle with out_valid=0.
REQ-015 busy SHALL be 1 in every state except IDLE; new start is accepted the first cycle after return to IDLE.
REQ-016 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN.

Reset
REQ-017 rstn=0 SHALL asynchronously force FSM=IDLE, accumulators=0, element counter=0, in_ready=0, out_valid=0, busy=0, sat_flag=0, result=0.
REQ-018 Reset mid-frame SHALL abort it; no partial result is emitted after rstn deasserts.

Structure
REQ-019 Shared package fc_pkg SHALL hold the FSM state enum, the SCALE table, RESCALE_SHIFT=16, and saturation helper functions.
REQ-020 One sub-module fc_lane (accumulate, bias, ReLU, rescale for one neuron) SHALL be instantiated NUM_PARA times; control FSM and counter stay in the top.

Verification
REQ-021 cfg_len=2, layer 0, in_data 200,200, lane0 weights 100,100, bias 100 -> result[0]=121, sat_flag=0, out_valid 3 cycles after FINISH entry.
REQ-022 Same frame, lane1 weights -100,-100 -> result[1]=0 (ReLU); with cfg_layer=3 lane0 -> 156.
REQ-023 cfg_len=512, in_data 255, weight 127 all elements -> accumulator saturates 8388607, sat_flag=1, result=255.
REQ-024 cfg_len=0, bias 127, cfg_layer=3 -> no in_ready pulse, result=0 (127>>8), out_valid 3 cycles after start.
REQ-025 Hold out_ready=0 10 cycles with out_valid=1 -> result stable, start ignored, in_ready=0; release -> IDLE next cycle.
REQ-026 Assert rstn=0 after 5 of 8 elements -> all outputs 0 immediately; next full frame yields correct result with no residue.
